grant_mux: RTL and testbench

- Downstream consumer of the round-robin arbiter's registered one-hot grant.
- Qualifies the grant against the live request vector and captures the granted requester's payload into a 2-entry output skid buffer.
- Pulses a per-requester ack and presents the winning payload, with its source index, on a valid/ready output port toward the shared resource.

---
 rtl/grant_mux_pkg.sv | 31 +++
 rtl/grant_mux_if.sv | 38 +++
 rtl/grant_mux_skid.sv | 65 ++++++
 rtl/grant_mux.sv | 103 ++++++++++
 tb/tb_grant_mux.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/grant_mux_pkg.sv
// Shared constants and helpers for grant_mux: index width and one-hot decoding.
package grant_mux_pkg;

  // Widest requester vector the helper functions accept.
  localparam int unsigned MaxN = 32;

  // Width of the source-index field; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned NDefault    = 5;
  localparam int unsigned WDefault    = 8;
  localparam int unsigned IdxwDefault = idx_width(NDefault);

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int unsigned onehot_to_idx(input logic [MaxN-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = MaxN - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // True when more than one bit is set (clearing the lowest bit leaves something).
  function automatic logic popcount_gt1(input logic [MaxN-1:0] v);
    return (v & (v - MaxN'(1))) != '0;
  endfunction

endpackage

// File: rtl/grant_mux_if.sv
// Requester-side and output-side signals of grant_mux.
// Optional drop_cnt field is present only when GRANT_MUX_STATS_EN is defined.
interface grant_mux_if #(
  parameter int unsigned N    = 5,
  parameter int unsigned W    = 8,
  parameter int unsigned IDXW = 3
);
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [N*W-1:0]  data_in;
  logic [N-1:0]    ack;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [IDXW-1:0] out_src;
  logic            err_onehot;
`ifdef GRANT_MUX_STATS_EN
  logic [15:0]     drop_cnt;

  modport master (
    output req, grant, data_in, out_ready,
    input  ack, out_valid, out_data, out_src, err_onehot, drop_cnt
  );
  modport slave (
    input  req, grant, data_in, out_ready,
    output ack, out_valid, out_data, out_src, err_onehot, drop_cnt
  );
`else
  modport master (
    output req, grant, data_in, out_ready,
    input  ack, out_valid, out_data, out_src, err_onehot
  );
  modport slave (
    input  req, grant, data_in, out_ready,
    output ack, out_valid, out_data, out_src, err_onehot
  );
`endif
endinterface

// File: rtl/grant_mux_skid.sv
// Two-entry FIFO holding captured {src, data} entries for grant_mux.
// Caller only pushes when there is room (count < 2, or a pop in the same cycle).
module grant_mux_skid #(
  parameter int unsigned W    = 8,
  parameter int unsigned IDXW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [IDXW+W-1:0]    push_data_i,  // {src, data}
  input  logic                 pop_i,
  output logic [IDXW+W-1:0]    head_o,
  output logic [1:0]           count_o
);

  logic [IDXW+W-1:0] mem_q [2];
  logic [IDXW+W-1:0] mem_d [2];
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic [1:0]        count_q, count_d;
  logic              pop_eff;

  // Popping an empty buffer is a no-op.
  assign pop_eff = pop_i & (count_q != 2'd0);

  // Next-state: write at wptr, advance pointers, track occupancy.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) begin
      mem_d[wptr_q] = push_data_i;
      wptr_d        = ~wptr_q;
    end
    if (pop_eff) begin
      rptr_d = ~rptr_q;
    end
    unique case ({push_i, pop_eff})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State register; reset discards all buffered entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/grant_mux.sv
// Qualifies the arbiter's one-hot grant against live requests, acks the winner and
// captures its payload into a 2-entry output buffer.
// GRANT_MUX_STATS_EN adds a saturating drop counter (drop_cnt).
module grant_mux
  import grant_mux_pkg::*;
#(
  parameter int unsigned N    = NDefault,
  parameter int unsigned W    = WDefault,
  parameter int unsigned IDXW = idx_width(N)
) (
  input  logic        clk,
  input  logic        rst,
  grant_mux_if.slave  bus_io
);

  logic [N-1:0]      qg;
  logic [N-1:0]      qg_low;
  logic [MaxN-1:0]   qg_ext;
  logic              qg_any;
  logic [W-1:0]      sel_data;
  logic [IDXW-1:0]   sel_src;
  logic [IDXW+W-1:0] head;
  logic [1:0]        count;
  logic              out_valid;
  logic              pop, space, push, drop;
  logic              err_q, err_d;

  // A grant whose requester has already dropped req is ignored entirely.
  assign qg     = bus_io.grant & bus_io.req;
  assign qg_ext = MaxN'(qg);
  assign qg_any = (qg != '0);
  // Lowest set bit wins if the grant is not one-hot.
  assign qg_low = qg & (~qg + N'(1));
  assign sel_src = IDXW'(onehot_to_idx(qg_ext));

  // Select the winning requester's payload slice.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (qg_low[i]) sel_data = bus_io.data_in[i*W +: W];
    end
  end

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & bus_io.out_ready;
  // Full buffer still accepts a push when the head leaves in the same cycle.
  assign space     = (count != 2'd2) | pop;
  assign push      = qg_any & space & ~rst;
  assign drop      = qg_any & ~space;

  grant_mux_skid #(
    .W    (W),
    .IDXW (IDXW)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({sel_src, sel_data}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus_io.ack       = push ? qg_low : '0;
  assign bus_io.out_valid = out_valid;
  assign bus_io.out_data  = head[W-1:0];
  assign bus_io.out_src   = head[IDXW+W-1:W];
  assign bus_io.err_onehot = err_q;

  // Sticky multi-hot grant flag.
  always_comb begin
    err_d = err_q | popcount_gt1(qg_ext);
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

`ifdef GRANT_MUX_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of cycles where a live grant found no room.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= 16'd0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign bus_io.drop_cnt = drop_cnt_q;
`else
  // Drops are not tracked in this build.
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_grant_mux.sv
// Directed bench for grant_mux (N=5, W=8) with immediate-assertion checks.
module tb_grant_mux;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  grant_mux_if #(.N(5), .W(8), .IDXW(3)) bus ();

  grant_mux #(
    .N    (5),
    .W    (8),
    .IDXW (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] g);
    bus.req   = r;
    bus.grant = g;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    // slices: 0=11, 1=22, 2=A5, 3=33, 4=44
    bus.data_in = {8'h44, 8'h33, 8'hA5, 8'h22, 8'h11};
    drive(5'b00100, 5'b00100);
    tick();
    #1;
    chk("rst_ack",       32'(bus.ack), 32'h0);
    chk("rst_valid",     32'(bus.out_valid), 32'h0);
    chk("rst_data",      32'(bus.out_data), 32'h0);
    chk("rst_src",       32'(bus.out_src), 32'h0);
    chk("rst_err",       32'(bus.err_onehot), 32'h0);
`ifdef GRANT_MUX_STATS_EN
    chk("rst_drop",      32'(bus.drop_cnt), 32'h0);
`endif
    drive(5'b00000, 5'b00000);
    tick();
    rst = 1'b0;

    // Single grant into empty buffer, drained immediately.
    bus.out_ready = 1'b1;
    drive(5'b00100, 5'b00100);
    #1;
    chk("t1_ack",        32'(bus.ack), 32'h04);
    chk("t1_valid_pre",  32'(bus.out_valid), 32'h0);
    tick();
    drive(5'b00000, 5'b00000);
    #1;
    chk("t1_valid",      32'(bus.out_valid), 32'h1);
    chk("t1_data",       32'(bus.out_data), 32'hA5);
    chk("t1_src",        32'(bus.out_src), 32'h2);
    chk("t1_ack_after",  32'(bus.ack), 32'h0);
    tick();
    chk("t1_empty",      32'(bus.out_valid), 32'h0);

    // Stall output; grants to 0, 1, then 3 (third finds buffer full).
    bus.out_ready = 1'b0;
    drive(5'b00001, 5'b00001);
    #1;
    chk("t2_ack0",       32'(bus.ack), 32'h01);
    tick();
    drive(5'b00010, 5'b00010);
    #1;
    chk("t2_ack1",       32'(bus.ack), 32'h02);
    tick();
    drive(5'b01000, 5'b01000);
    #1;
    chk("t2_ack3_drop",  32'(bus.ack), 32'h0);
    tick();
    drive(5'b00000, 5'b00000);
    #1;
    chk("t2_valid",      32'(bus.out_valid), 32'h1);
    chk("t2_head_src",   32'(bus.out_src), 32'h0);
    chk("t2_head_data",  32'(bus.out_data), 32'h11);
`ifdef GRANT_MUX_STATS_EN
    chk("t2_drop_cnt",   32'(bus.drop_cnt), 32'h1);
`endif
    tick();
    chk("t2_hold_src",   32'(bus.out_src), 32'h0);
    chk("t2_hold_data",  32'(bus.out_data), 32'h11);

    // Full buffer: pop and push of requester 4 in the same cycle.
    bus.out_ready = 1'b1;
    drive(5'b10000, 5'b10000);
    #1;
    chk("t3_ack4",       32'(bus.ack), 32'h10);
    tick();
    bus.out_ready = 1'b0;
    drive(5'b00001, 5'b00001);
    #1;
    chk("t3_head_src",   32'(bus.out_src), 32'h1);
    chk("t3_head_data",  32'(bus.out_data), 32'h22);
    // Still full, so this grant is dropped.
    chk("t3_full_ack",   32'(bus.ack), 32'h0);
    tick();
    drive(5'b00000, 5'b00000);
    bus.out_ready = 1'b1;
`ifdef GRANT_MUX_STATS_EN
    #1;
    chk("t3_drop_cnt",   32'(bus.drop_cnt), 32'h2);
`endif
    tick();
    chk("t3_src4",       32'(bus.out_src), 32'h4);
    chk("t3_data4",      32'(bus.out_data), 32'h44);
    chk("t3_valid4",     32'(bus.out_valid), 32'h1);
    tick();
    chk("t3_drained",    32'(bus.out_valid), 32'h0);

    // Stale grant: requester already dropped req.
    drive(5'b00000, 5'b00010);
    #1;
    chk("t4_ack",        32'(bus.ack), 32'h0);
    tick();
    drive(5'b00000, 5'b00000);
    #1;
    chk("t4_valid",      32'(bus.out_valid), 32'h0);
`ifdef GRANT_MUX_STATS_EN
    chk("t4_drop_cnt",   32'(bus.drop_cnt), 32'h2);
`endif

    // Multi-hot grant: lowest bit wins, error flag becomes sticky.
    bus.out_ready = 1'b0;
    drive(5'b01010, 5'b01010);
    #1;
    chk("t5_ack",        32'(bus.ack), 32'h02);
    chk("t5_err_pre",    32'(bus.err_onehot), 32'h0);
    tick();
    drive(5'b00000, 5'b00000);
    #1;
    chk("t5_err",        32'(bus.err_onehot), 32'h1);
    chk("t5_src",        32'(bus.out_src), 32'h1);
    chk("t5_data",       32'(bus.out_data), 32'h22);
    tick();
    chk("t5_err_sticky", 32'(bus.err_onehot), 32'h1);

    // Second entry, then asynchronous reset mid-cycle.
    drive(5'b10000, 5'b10000);
    tick();
    drive(5'b00001, 5'b00001);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid",      32'(bus.out_valid), 32'h0);
    chk("t6_err",        32'(bus.err_onehot), 32'h0);
    chk("t6_ack",        32'(bus.ack), 32'h0);
`ifdef GRANT_MUX_STATS_EN
    chk("t6_drop_cnt",   32'(bus.drop_cnt), 32'h0);
`endif
    tick();
    drive(5'b00000, 5'b00000);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("t6_discarded",  32'(bus.out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
